// File: rtl/neuron_accumulate.sv
// neuron_accumulate: reduces a frame of N_INPUTS signed 2-bit synapse
// products into a saturated signed sum and a threshold spike.
// The frame sequencer is IDLE -> ACCUM -> DONE. DONE lasts one cycle and
// presents the registered result with a one-cycle out_valid pulse.
module neuron_accumulate #(
    parameter int N_INPUTS  = 8,
    parameter int ACC_WIDTH = 5,
    parameter int THRESHOLD = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        y_valid,
    input  logic signed [1:0]           y,
    output logic                        busy,
    output logic                        out_valid,
    output logic                        out_spike,
    output logic signed [ACC_WIDTH-1:0] out_sum
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] THR     = ACC_WIDTH'(THRESHOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                        state;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic [CNT_W-1:0]              count;
    logic signed [ACC_WIDTH-1:0]   acc_next;

    // Add one sign-extended product one bit wider than the accumulator, then
    // clamp. A single 2-bit addend can overflow by at most one step, so a
    // disagreement between the two top bits identifies overflow and its
    // direction.
    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [1:0]           p
    );
        logic signed [ACC_WIDTH:0] wide;
        wide = $signed({a[ACC_WIDTH-1], a}) + $signed({{(ACC_WIDTH-1){p[1]}}, p});
        if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1])
            sat_add = wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        else
            sat_add = wide[ACC_WIDTH-1:0];
    endfunction

    // Candidate accumulator value if the current product is accepted.
    always_comb begin
        acc_next = sat_add(acc, y);
    end

    // Frame sequencer. It owns the accumulator, the product count and all
    // registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_spike <= 1'b0;
            out_sum   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    // Products are ignored here, including in the start cycle.
                    if (start) begin
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    out_valid <= 1'b0;
                    if (start) begin
                        // Abort: restart the frame and discard this cycle's product.
                        acc   <= '0;
                        count <= '0;
                    end else if (y_valid) begin
                        acc   <= acc_next;
                        count <= count + 1'b1;
                        if (count == LAST_IDX) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            out_sum   <= acc_next;
                            out_spike <= (acc_next >= THR);
                        end
                    end
                end
                DONE: begin
                    out_valid <= 1'b0;
                    acc       <= '0;
                    count     <= '0;
                    // A start here chains directly into the next frame.
                    if (start) begin
                        busy  <= 1'b1;
                        state <= ACCUM;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/neuron_accumulate.md
# neuron_accumulate

Ternary-neuron accumulator that consumes the signed 2-bit products emitted by `synapse_mul`, one per cycle, and reduces a frame of N_INPUTS products into a saturated signed sum plus a binary spike (sum ≥ THRESHOLD). It is the downstream end of the synapse output interface. It sits between the synapse array and the top-level `uo_out` pins, or feeds the next layer's `x` input, inside `tt_um_rejunity_fractal_nn`.

## Interface
Parameters:
- N_INPUTS, 8, products per frame; ≥ 1.
- ACC_WIDTH, 5, signed accumulator width; ≥ 2.
- THRESHOLD, 1, signed spike threshold; must fit in ACC_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin new frame; clears accumulator and count.
- y_valid  in  1  y carries a product this cycle.
- y  in  2  signed synapse product: 00=0, 01=+1, 11=−1, 10=−2 (sign-extended, accepted arithmetically).
- busy  out  1  high while in ACCUM.
- out_valid  out  1  one-cycle pulse: frame result is ready.
- out_spike  out  1  registered (out_sum ≥ THRESHOLD); held until next out_valid.
- out_sum  out  ACC_WIDTH  registered signed frame sum; held until next out_valid.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 → acc=0, count=0, go to ACCUM.
  - y_valid is ignored in IDLE, including in the start cycle.
- ACCUM:
  - Each cycle with y_valid=1: acc ← sat(acc + sext(y)), count ← count+1.
  - Cycles with y_valid=0 leave acc and count unchanged; gaps are unlimited.
  - The accepted product that makes count == N_INPUTS → go to DONE. acc is final.
- DONE (exactly one cycle):
  - out_valid=1. out_sum ← acc and out_spike ← (acc ≥ THRESHOLD), both loaded on entry so they are valid while out_valid is high.
  - Next state is IDLE. If start=1 in DONE, next state is ACCUM with acc/count cleared.
- Saturation:
  - The sum is computed at ACC_WIDTH+1 bits, then clamped to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
  - The accumulator never wraps.
- start in ACCUM aborts the frame: acc=0, count=0, stay in ACCUM. No out_valid for the aborted frame. y in that cycle is discarded.
- Comparison is signed.
- out_sum/out_spike change only when DONE is entered.
- Count register width is clog2(N_INPUTS+1).

## Timing
- Reset (async assert, sync-safe release):
  - Go to IDLE; acc=0, count=0.
  - busy=0, out_valid=0, out_spike=0, out_sum=0.
- busy rises the cycle after start is sampled in IDLE. It falls the cycle after the final product is accepted.
- Latency: final product sampled at edge k → out_valid high during cycle k+1 (between edges k and k+1).
- Minimum frame: N_INPUTS+2 cycles (start cycle, N accept cycles, DONE). Back-to-back frames are achieved via start in DONE.
- Reset asserted mid-frame discards everything. No out_valid is produced for that frame.
- out_valid never asserts twice for one frame and never two cycles in a row.

## Test plan
- Defaults; start, then 8 × y=01 with y_valid every cycle → out_valid one cycle after 8th accept; out_sum=8, out_spike=1.
- Defaults; 8 products 01,11,00,01,11,11,00,11 with y_valid low every other cycle → out_sum=−2, out_spike=0; busy high throughout the gapped frame.
- ACC_WIDTH=4; 8 × 01 → out_sum=7 (clamped); 8 × 10 → out_sum=−8 (clamped), out_spike=0.
- Defaults; start, 5 × 01, start again, then 8 × 11 → exactly one out_valid; out_sum=−8. start asserted in DONE → next frame begins immediately; busy=1 the following cycle.
- Reset asserted mid-frame after 4 products → all outputs 0 immediately. A following full frame of 8 × 00 → out_sum=0, out_spike=0 (0 < THRESHOLD=1).
- y_valid=1 with y=01 while IDLE (no start) for 10 cycles → out_valid never asserts; out_sum unchanged.
